bullet_ctrl: RTL

Per-player bullet lifecycle controller for the tank game.
- Turns a fire button into a single bullet, steps its position once per video frame in the tank's facing direction, and reacts to the per-pixel hit flag from the collision logic.
- Sequences the explosion animation window and a refire cooldown.
- One instance per player. Its bullet_active_o/x/y feed the bullet sprite renderer, whose pixel flag feeds the collision block; that block's explose flag returns here as explose_i.

---
 rtl/tank_pkg.sv | 24 ++
 rtl/frame_down_counter.sv | 36 +++
 rtl/bullet_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared types and screen defaults for the tank game datapath blocks.
package tank_pkg;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned COORD_W_DEF  = 10;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirRight = 2'd1,
        DirDown  = 2'd2,
        DirLeft  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFly      = 2'd1,
        StExplode  = 2'd2,
        StCooldown = 2'd3
    } bullet_state_e;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame-tick down counter; done_o pulses on the tick that consumes the last count.
module frame_down_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             tick_i,
    output logic [Width-1:0] count_o,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = tick_i && (count_q == Width'(1));

endmodule

// File: rtl/bullet_ctrl.sv
// Per-player bullet lifecycle: fire, per-frame flight, explosion window and refire cooldown.
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int unsigned SCREEN_W        = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H        = SCREEN_H_DEF,
    parameter int unsigned COORD_W         = COORD_W_DEF,
    parameter int unsigned BULLET_SPEED    = 4,
    parameter int unsigned EXPLODE_FRAMES  = 8,
    parameter int unsigned COOLDOWN_FRAMES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_tick_i,
    input  logic               fire_i,
    input  logic [COORD_W-1:0] tank_x_i,
    input  logic [COORD_W-1:0] tank_y_i,
    input  logic [1:0]         tank_dir_i,
    input  logic               explose_i,
    output logic               bullet_active_o,
    output logic [COORD_W-1:0] bullet_x_o,
    output logic [COORD_W-1:0] bullet_y_o,
    output logic               exploding_o,
    output logic               ready_o
);

    localparam int unsigned MaxFrames =
        (EXPLODE_FRAMES > COOLDOWN_FRAMES) ? EXPLODE_FRAMES : COOLDOWN_FRAMES;
    localparam int unsigned CntW = $clog2(MaxFrames + 1);

    localparam logic [COORD_W:0] SpeedExt = (COORD_W+1)'(BULLET_SPEED);
    localparam logic [COORD_W:0] XMax     = (COORD_W+1)'(SCREEN_W - 1);
    localparam logic [COORD_W:0] YMax     = (COORD_W+1)'(SCREEN_H - 1);

    bullet_state_e      state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               fire_prev_q;
    logic               fire_edge;

    logic            cnt_load, cnt_tick, cnt_done;
    logic [CntW-1:0] cnt_val, cnt_count;

    logic [COORD_W:0] x_ext, y_ext, x_step, y_step;
    logic             out_of_range;

    assign fire_edge = fire_i && !fire_prev_q;
    assign cnt_tick  = frame_tick_i && ((state_q == StExplode) || (state_q == StCooldown));

    // One extra bit so an underflow past 0 or overflow past the edge is visible.
    always_comb begin
        x_ext        = {1'b0, x_q};
        y_ext        = {1'b0, y_q};
        x_step       = x_ext;
        y_step       = y_ext;
        out_of_range = 1'b0;
        case (dir_q)
            DirUp: begin
                out_of_range = (y_ext < SpeedExt);
                y_step       = y_ext - SpeedExt;
            end
            DirDown: begin
                y_step       = y_ext + SpeedExt;
                out_of_range = (y_step > YMax);
            end
            DirLeft: begin
                out_of_range = (x_ext < SpeedExt);
                x_step       = x_ext - SpeedExt;
            end
            DirRight: begin
                x_step       = x_ext + SpeedExt;
                out_of_range = (x_step > XMax);
            end
            default: out_of_range = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            StIdle: begin
                if (fire_edge) begin
                    x_d     = tank_x_i;
                    y_d     = tank_y_i;
                    dir_d   = dir_e'(tank_dir_i);
                    state_d = StFly;
                end
            end
            StFly: begin
                // A hit beats a same-cycle frame tick, so the explosion sits where the hit was seen.
                if (explose_i) begin
                    state_d  = StExplode;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(EXPLODE_FRAMES);
                end else if (frame_tick_i) begin
                    if (out_of_range) begin
                        state_d  = StCooldown;
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(COOLDOWN_FRAMES);
                    end else begin
                        x_d = x_step[COORD_W-1:0];
                        y_d = y_step[COORD_W-1:0];
                    end
                end
            end
            StExplode: begin
                if (cnt_done) begin
                    state_d  = StCooldown;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(COOLDOWN_FRAMES);
                end
            end
            StCooldown: begin
                if ((COOLDOWN_FRAMES == 0) || cnt_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            dir_q       <= DirUp;
            x_q         <= '0;
            y_q         <= '0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fire_prev_q <= fire_i;
        end
    end

    frame_down_counter #(
        .Width (CntW)
    ) u_frame_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tick_i     (cnt_tick),
        .count_o    (cnt_count),
        .done_o     (cnt_done)
    );

    assign bullet_active_o = (state_q == StFly);
    assign exploding_o     = (state_q == StExplode);
    assign ready_o         = (state_q == StIdle);
    assign bullet_x_o      = x_q;
    assign bullet_y_o      = y_q;

endmodule
